// File: rtl/wdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wdm_pkg
// Brief    : Shared types and defaults for the WDM tuning blocks.
// Revision : 1.0 - initial release
// ============================================================================
package wdm_pkg;

    localparam int TUNER_SEARCH_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } tuner_search_host_state_e;

endpackage
`default_nettype wire

// File: rtl/tuner_search_host.sv
`default_nettype none
// ============================================================================
// Module   : tuner_search_host
// Brief    : Issues search triggers, collects peak lists, selects the ordinal
//            peak against a power floor, and retries on weak peaks/timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module tuner_search_host
    import wdm_pkg::*;
#(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int NUM_TARGET     = 4,
    parameter int TIMEOUT_CYCLES = TUNER_SEARCH_TIMEOUT_DEFAULT,
    parameter int MAX_RETRY      = 3
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_cmd_val,
    output logic                                   o_cmd_rdy,
    input  logic [$clog2(NUM_TARGET)-1:0]          i_cmd_target_idx,
    input  logic [ADC_WIDTH-1:0]                   i_cmd_min_pwr,
    output logic                                   o_search_trig_val,
    input  logic                                   i_search_trig_rdy,
    input  logic                                   i_search_peaks_val,
    output logic                                   o_search_peaks_rdy,
    input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]   i_search_ring_tune_peaks,
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]   i_search_pwr_peaks,
    input  logic [$clog2(NUM_TARGET)-1:0]          i_search_peaks_cnt,
    output logic                                   o_lock_val,
    input  logic                                   i_lock_rdy,
    output logic [DAC_WIDTH-1:0]                   o_lock_ring_tune,
    output logic [ADC_WIDTH-1:0]                   o_lock_pwr,
    output logic                                   o_lock_err,
    output tuner_search_host_state_e               o_mon_state,
    output logic [$clog2(MAX_RETRY+1)-1:0]         o_mon_retry_cnt
);

    localparam int IDX_W = $clog2(NUM_TARGET);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]     c_tmr_last  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0]     c_retry_max = RTY_W'(MAX_RETRY);
    localparam logic [ADC_WIDTH-1:0] c_pwr_floor = ADC_WIDTH'(1);

    tuner_search_host_state_e r_state;
    tuner_search_host_state_e w_state_nxt;

    logic [IDX_W-1:0]                  r_idx;
    logic [ADC_WIDTH-1:0]              r_min_pwr;
    logic [RTY_W-1:0]                  r_retry;
    logic [TMR_W-1:0]                  r_timer;
    logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] r_tune_peaks;
    logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] r_pwr_peaks;
    logic [IDX_W-1:0]                  r_cnt;
    logic [DAC_WIDTH-1:0]              r_lock_tune;
    logic [ADC_WIDTH-1:0]              r_lock_pwr;
    logic                              r_lock_err;

    logic w_pass;
    logic w_timeout;
    logic w_fail;
    logic w_retry_left;

    always_comb begin
        w_state_nxt  = r_state;
        w_pass       = (r_idx <= r_cnt) && (r_pwr_peaks[r_idx] >= r_min_pwr);
        // Peaks arriving on the terminal count take priority over the timeout.
        w_timeout    = (r_state == WAIT) && !i_search_peaks_val && (r_timer == c_tmr_last);
        w_fail       = ((r_state == CHECK) && !w_pass) || w_timeout;
        w_retry_left = (r_retry < c_retry_max);

        case (r_state)
            IDLE:    if (i_cmd_val)         w_state_nxt = TRIG;
            TRIG:    if (i_search_trig_rdy) w_state_nxt = WAIT;
            WAIT: begin
                if (i_search_peaks_val)     w_state_nxt = CHECK;
                else if (w_timeout)         w_state_nxt = w_retry_left ? TRIG : RESP;
            end
            CHECK: begin
                if (w_pass)                 w_state_nxt = RESP;
                else                        w_state_nxt = w_retry_left ? TRIG : RESP;
            end
            RESP:    if (i_lock_rdy)        w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_min_pwr    <= '0;
            r_retry      <= '0;
            r_timer      <= '0;
            r_tune_peaks <= '0;
            r_pwr_peaks  <= '0;
            r_cnt        <= '0;
            r_lock_tune  <= '0;
            r_lock_pwr   <= '0;
            r_lock_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == IDLE) && i_cmd_val) begin
                r_idx     <= i_cmd_target_idx;
                r_min_pwr <= (i_cmd_min_pwr == '0) ? c_pwr_floor : i_cmd_min_pwr;
                r_retry   <= '0;
            end

            if ((r_state == TRIG) && i_search_trig_rdy) begin
                r_timer <= '0;
            end

            if (r_state == WAIT) begin
                if (i_search_peaks_val) begin
                    r_tune_peaks <= i_search_ring_tune_peaks;
                    r_pwr_peaks  <= i_search_pwr_peaks;
                    r_cnt        <= i_search_peaks_cnt;
                end else if (r_timer != '1) begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            if ((r_state == CHECK) && w_pass) begin
                r_lock_tune <= r_tune_peaks[r_idx];
                r_lock_pwr  <= r_pwr_peaks[r_idx];
                r_lock_err  <= 1'b0;
            end

            // Timeout and weak/missing peak share one retry budget.
            if (w_fail) begin
                if (w_retry_left) begin
                    r_retry <= r_retry + 1'b1;
                end else begin
                    r_lock_tune <= '0;
                    r_lock_pwr  <= '0;
                    r_lock_err  <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_rdy          = (r_state == IDLE);
    assign o_search_trig_val  = (r_state == TRIG);
    assign o_search_peaks_rdy = (r_state == WAIT);
    assign o_lock_val         = (r_state == RESP);
    assign o_lock_ring_tune   = r_lock_tune;
    assign o_lock_pwr         = r_lock_pwr;
    assign o_lock_err         = r_lock_err;
    assign o_mon_state        = r_state;
    assign o_mon_retry_cnt    = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_tuner_search_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_tuner_search_host
// Brief    : Directed scoreboard bench for tuner_search_host with a PHY model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tuner_search_host;
    import wdm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 i_rst = 1'b1;
    logic                 i_cmd_val = 1'b0;
    logic                 o_cmd_rdy;
    logic [1:0]           i_cmd_target_idx = '0;
    logic [7:0]           i_cmd_min_pwr = '0;
    logic                 o_search_trig_val;
    logic                 i_search_trig_rdy = 1'b0;
    logic                 i_search_peaks_val = 1'b0;
    logic                 o_search_peaks_rdy;
    logic [3:0][7:0]      i_search_ring_tune_peaks = '0;
    logic [3:0][7:0]      i_search_pwr_peaks = '0;
    logic [1:0]           i_search_peaks_cnt = '0;
    logic                 o_lock_val;
    logic                 i_lock_rdy = 1'b0;
    logic [7:0]           o_lock_ring_tune;
    logic [7:0]           o_lock_pwr;
    logic                 o_lock_err;
    tuner_search_host_state_e o_mon_state;
    logic [1:0]           o_mon_retry_cnt;

    tuner_search_host #(
        .DAC_WIDTH      (8),
        .ADC_WIDTH      (8),
        .NUM_TARGET     (4),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRY      (3)
    ) dut (
        .i_clk                    (clk),
        .i_rst                    (i_rst),
        .i_cmd_val                (i_cmd_val),
        .o_cmd_rdy                (o_cmd_rdy),
        .i_cmd_target_idx         (i_cmd_target_idx),
        .i_cmd_min_pwr            (i_cmd_min_pwr),
        .o_search_trig_val        (o_search_trig_val),
        .i_search_trig_rdy        (i_search_trig_rdy),
        .i_search_peaks_val       (i_search_peaks_val),
        .o_search_peaks_rdy       (o_search_peaks_rdy),
        .i_search_ring_tune_peaks (i_search_ring_tune_peaks),
        .i_search_pwr_peaks       (i_search_pwr_peaks),
        .i_search_peaks_cnt       (i_search_peaks_cnt),
        .o_lock_val               (o_lock_val),
        .i_lock_rdy               (i_lock_rdy),
        .o_lock_ring_tune         (o_lock_ring_tune),
        .o_lock_pwr               (o_lock_pwr),
        .o_lock_err               (o_lock_err),
        .o_mon_state              (o_mon_state),
        .o_mon_retry_cnt          (o_mon_retry_cnt)
    );

    typedef struct {
        logic [7:0] tune;
        logic [7:0] pwr;
        logic       err;
        logic [1:0] retry;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   n_trig  = 0;

    always @(posedge clk) begin
        if (o_search_trig_val && i_search_trig_rdy) n_trig <= n_trig + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_lock(input logic [7:0] tune, input logic [7:0] pwr,
                               input logic err, input logic [1:0] retry);
        exp_t e;
        e.tune = tune; e.pwr = pwr; e.err = err; e.retry = retry;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] idx, input logic [7:0] minp);
        i_cmd_target_idx = idx;
        i_cmd_min_pwr    = minp;
        i_cmd_val        = 1'b1;
        check("cmd_rdy_idle", 32'(o_cmd_rdy), 1);
        check("trig_before_accept", 32'(o_search_trig_val), 0);
        tick();
        i_cmd_val = 1'b0;
        check("trig_1cyc_after_accept", 32'(o_search_trig_val), 1);
        check("cmd_rdy_busy", 32'(o_cmd_rdy), 0);
    endtask

    task automatic do_trig(input int n_low);
        i_search_trig_rdy = 1'b0;
        repeat (n_low) begin
            check("trig_held", 32'(o_search_trig_val), 1);
            tick();
        end
        i_search_trig_rdy = 1'b1;
        check("trig_held", 32'(o_search_trig_val), 1);
        tick();
        i_search_trig_rdy = 1'b0;
        check("peaks_rdy_in_wait", 32'(o_search_peaks_rdy), 1);
    endtask

    task automatic give_peaks(input int delay, input logic [3:0][7:0] tune,
                              input logic [3:0][7:0] pwr, input logic [1:0] cnt);
        i_search_peaks_val = 1'b0;
        repeat (delay) tick();
        i_search_ring_tune_peaks = tune;
        i_search_pwr_peaks       = pwr;
        i_search_peaks_cnt       = cnt;
        i_search_peaks_val       = 1'b1;
        check("peaks_rdy_at_val", 32'(o_search_peaks_rdy), 1);
        tick();
        i_search_peaks_val = 1'b0;
    endtask

    task automatic wait_trig();
        int n = 0;
        while (!o_search_trig_val && n < 100) begin
            tick();
            n++;
        end
        check("retrigger_seen", 32'(o_search_trig_val), 1);
    endtask

    task automatic get_lock(input int rdy_delay);
        int   n = 0;
        exp_t e;
        while (!o_lock_val && n < 200) begin
            tick();
            n++;
        end
        check("lock_val_seen", 32'(o_lock_val), 1);
        check("sb_depth", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("lock_tune", 32'(o_lock_ring_tune), 32'(e.tune));
            check("lock_pwr", 32'(o_lock_pwr), 32'(e.pwr));
            check("lock_err", 32'(o_lock_err), 32'(e.err));
            check("retry_cnt", 32'(o_mon_retry_cnt), 32'(e.retry));
            repeat (rdy_delay) begin
                tick();
                check("lock_val_stable", 32'(o_lock_val), 1);
                check("lock_tune_stable", 32'(o_lock_ring_tune), 32'(e.tune));
                check("lock_pwr_stable", 32'(o_lock_pwr), 32'(e.pwr));
                check("lock_err_stable", 32'(o_lock_err), 32'(e.err));
            end
        end
        i_lock_rdy = 1'b1;
        tick();
        i_lock_rdy = 1'b0;
        check("lock_val_drop", 32'(o_lock_val), 0);
        check("cmd_rdy_after_lock", 32'(o_cmd_rdy), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int n;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_rdy", 32'(o_cmd_rdy), 1);
        check("rst_trig_val", 32'(o_search_trig_val), 0);
        check("rst_peaks_rdy", 32'(o_search_peaks_rdy), 0);
        check("rst_lock_val", 32'(o_lock_val), 0);
        check("rst_lock_tune", 32'(o_lock_ring_tune), 0);
        check("rst_lock_err", 32'(o_lock_err), 0);
        check("rst_state", 32'(o_mon_state), 32'(IDLE));
        i_rst = 1'b0;
        tick();

        // Pass on first attempt
        t0 = n_trig;
        send_cmd(2'd1, 8'd40);
        expect_lock(8'd75, 8'd120, 1'b0, 2'd0);
        do_trig(0);
        give_peaks(3, {8'd0, 8'd130, 8'd75, 8'd20}, {8'd0, 8'd60, 8'd120, 8'd90}, 2'd2);
        check("lock_not_yet", 32'(o_lock_val), 0);
        tick();
        check("lock_2cyc_after_peaks", 32'(o_lock_val), 1);
        get_lock(0);
        check("trig_count_pass", 32'(n_trig - t0), 1);

        // Weak peak, then good peak on retry
        t0 = n_trig;
        send_cmd(2'd1, 8'd40);
        expect_lock(8'd80, 8'd100, 1'b0, 2'd1);
        do_trig(0);
        give_peaks(2, {8'd0, 8'd130, 8'd75, 8'd20}, {8'd0, 8'd60, 8'd10, 8'd90}, 2'd2);
        wait_trig();
        check("retry_after_weak", 32'(o_mon_retry_cnt), 1);
        do_trig(0);
        give_peaks(1, {8'd0, 8'd130, 8'd80, 8'd20}, {8'd0, 8'd60, 8'd100, 8'd90}, 2'd2);
        get_lock(0);
        check("trig_count_retry", 32'(n_trig - t0), 2);

        // Out-of-range index exhausts every attempt
        t0 = n_trig;
        send_cmd(2'd3, 8'd40);
        expect_lock(8'd0, 8'd0, 1'b1, 2'd3);
        for (int a = 0; a < 4; a++) begin
            if (a > 0) wait_trig();
            do_trig(0);
            give_peaks(1, {8'd99, 8'd98, 8'd97, 8'd96}, {8'd200, 8'd200, 8'd200, 8'd200}, 2'd1);
        end
        get_lock(0);
        check("trig_count_range", 32'(n_trig - t0), 4);

        // Zero power floor behaves as 1; idx == cnt is in range
        send_cmd(2'd0, 8'd0);
        expect_lock(8'd11, 8'd1, 1'b0, 2'd1);
        do_trig(0);
        give_peaks(0, {8'd0, 8'd0, 8'd0, 8'd10}, {8'd50, 8'd50, 8'd50, 8'd0}, 2'd0);
        wait_trig();
        do_trig(0);
        give_peaks(0, {8'd0, 8'd0, 8'd0, 8'd11}, {8'd50, 8'd50, 8'd50, 8'd1}, 2'd0);
        get_lock(0);

        // Timeout: PHY never answers
        t0 = n_trig;
        send_cmd(2'd0, 8'd1);
        expect_lock(8'd0, 8'd0, 1'b1, 2'd3);
        for (int a = 0; a < 4; a++) begin
            do_trig(0);
            n = 0;
            while (!(o_search_trig_val || o_lock_val) && n < 40) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 16);
        end
        get_lock(0);
        check("trig_count_timeout", 32'(n_trig - t0), 4);

        // Peaks on the terminal timeout cycle win
        t0 = n_trig;
        send_cmd(2'd2, 8'd50);
        expect_lock(8'd33, 8'd77, 1'b0, 2'd0);
        do_trig(0);
        give_peaks(15, {8'd0, 8'd33, 8'd22, 8'd11}, {8'd0, 8'd77, 8'd5, 8'd5}, 2'd2);
        get_lock(0);
        check("trig_count_corner", 32'(n_trig - t0), 1);

        // Backpressure on trigger and result
        send_cmd(2'd0, 8'd30);
        expect_lock(8'd44, 8'd31, 1'b0, 2'd0);
        do_trig(5);
        give_peaks(0, {8'd1, 8'd2, 8'd3, 8'd44}, {8'd9, 8'd9, 8'd9, 8'd31}, 2'd3);
        get_lock(7);

        // Reset mid-WAIT with peaks presented
        send_cmd(2'd1, 8'd40);
        do_trig(0);
        i_search_ring_tune_peaks = {8'd0, 8'd130, 8'd75, 8'd20};
        i_search_pwr_peaks       = {8'd0, 8'd60, 8'd120, 8'd90};
        i_search_peaks_cnt       = 2'd2;
        i_search_peaks_val       = 1'b1;
        i_rst                    = 1'b1;
        tick();
        i_rst              = 1'b0;
        i_search_peaks_val = 1'b0;
        check("midrst_state", 32'(o_mon_state), 32'(IDLE));
        check("midrst_peaks_rdy", 32'(o_search_peaks_rdy), 0);
        check("midrst_lock_val", 32'(o_lock_val), 0);
        check("midrst_cmd_rdy", 32'(o_cmd_rdy), 1);
        check("midrst_lock_tune", 32'(o_lock_ring_tune), 0);
        repeat (4) begin
            tick();
            check("no_stale_lock", 32'(o_lock_val), 0);
        end
        check("sb_empty_after_rst", 32'(sb.size()), 0);

        // Normal operation after reset; power equal to floor passes
        send_cmd(2'd2, 8'd200);
        expect_lock(8'd150, 8'd200, 1'b0, 2'd0);
        do_trig(0);
        give_peaks(2, {8'd0, 8'd150, 8'd75, 8'd20}, {8'd0, 8'd200, 8'd120, 8'd90}, 2'd3);
        get_lock(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
